// File: rtl/axis_lfsr_crc_engine.sv
// Runtime-configurable LFSR/CRC engine: PRBS generation, per-packet CRC append and PRBS checking
// between AXI-Stream ports, with a registered output stage.
module axis_lfsr_crc_engine #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CRC_WIDTH     = 16,
    parameter int unsigned ERR_CNT_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic [1:0]               mode_i,
    input  logic [DATA_WIDTH-1:0]    poly_i,
    input  logic [DATA_WIDTH-1:0]    seed_i,
    input  logic [CRC_WIDTH-1:0]     crc_init_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    if (CRC_WIDTH < 1 || CRC_WIDTH > DATA_WIDTH) begin : g_bad_crc_width
        $error("CRC_WIDTH must be in 1..DATA_WIDTH");
    end

    typedef enum logic [0:0] {StData, StCrc} state_e;

    localparam logic [1:0] ModeCrc = 2'd1;
    localparam logic [1:0] ModeChk = 2'd2;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v,
                                                        input logic [DATA_WIDTH-1:0] poly);
        return (v << 1) ^ (v[DATA_WIDTH-1] ? poly : '0);
    endfunction

    function automatic logic [CRC_WIDTH-1:0] crc_update(input logic [CRC_WIDTH-1:0]  crc,
                                                        input logic [DATA_WIDTH-1:0] d,
                                                        input logic [CRC_WIDTH-1:0]  poly);
        logic [CRC_WIDTH-1:0] c;
        c = crc;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            c = (c << 1) ^ ((c[CRC_WIDTH-1] ^ d[i]) ? poly : '0);
        end
        return c;
    endfunction

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    lfsr_q, lfsr_d;
    logic                     lfsr_fresh_q, lfsr_fresh_d;
    logic [CRC_WIDTH-1:0]     crc_q, crc_d;
    logic                     crc_fresh_q, crc_fresh_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    logic [DATA_WIDTH-1:0]    lfsr_cur;
    logic [CRC_WIDTH-1:0]     crc_cur;
    logic [DATA_WIDTH-1:0]    crc_ext;
    logic                     load_ok;
    logic                     s_ready;

    // The fresh flags stand in for "register holds seed_i / crc_init_i", so reset and en_i=0
    // both start from the port values without an asynchronous load of a non-constant.
    always_comb begin
        lfsr_cur               = lfsr_fresh_q ? seed_i : lfsr_q;
        crc_cur                = crc_fresh_q ? crc_init_i : crc_q;
        crc_ext                = '0;
        crc_ext[CRC_WIDTH-1:0] = crc_cur;
        load_ok                = ~valid_q | m_axis_tready;

        state_d      = state_q;
        lfsr_d       = lfsr_q;
        lfsr_fresh_d = lfsr_fresh_q;
        crc_d        = crc_q;
        crc_fresh_d  = crc_fresh_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        err_d        = err_q;
        s_ready      = 1'b0;

        if (!en_i) begin
            state_d      = StData;
            lfsr_fresh_d = 1'b1;
            crc_fresh_d  = 1'b1;
            data_d       = '0;
            valid_d      = 1'b0;
            last_d       = 1'b0;
            err_d        = '0;
        end else begin
            if (valid_q && m_axis_tready) begin
                valid_d = 1'b0;
            end
            if (mode_i == ModeCrc) begin
                if (state_q == StData) begin
                    s_ready = load_ok;
                    if (s_axis_tvalid && load_ok) begin
                        data_d      = s_axis_tdata;
                        last_d      = 1'b0;
                        valid_d     = 1'b1;
                        crc_d       = crc_update(crc_cur, s_axis_tdata, poly_i[CRC_WIDTH-1:0]);
                        crc_fresh_d = 1'b0;
                        if (s_axis_tlast) begin
                            state_d = StCrc;
                        end
                    end
                end else if (load_ok) begin
                    data_d      = crc_ext;
                    last_d      = 1'b1;
                    valid_d     = 1'b1;
                    crc_fresh_d = 1'b1;
                    state_d     = StData;
                end
            end else if (mode_i == ModeChk) begin
                s_ready = 1'b1;
                valid_d = 1'b0;
                if (s_axis_tvalid) begin
                    if (s_axis_tdata != lfsr_cur && err_q != '1) begin
                        err_d = err_q + ERR_CNT_WIDTH'(1);
                    end
                    lfsr_d       = lfsr_step(lfsr_cur, poly_i);
                    lfsr_fresh_d = 1'b0;
                end
            end else if (load_ok) begin
                data_d       = lfsr_cur;
                last_d       = 1'b0;
                valid_d      = 1'b1;
                lfsr_d       = lfsr_step(lfsr_cur, poly_i);
                lfsr_fresh_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StData;
            lfsr_q       <= '0;
            lfsr_fresh_q <= 1'b1;
            crc_q        <= '0;
            crc_fresh_q  <= 1'b1;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            lfsr_fresh_q <= lfsr_fresh_d;
            crc_q        <= crc_d;
            crc_fresh_q  <= crc_fresh_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_axis_lfsr_crc_engine.sv
// Bench for axis_lfsr_crc_engine: an 8-bit instance for PRBS gen/check and CRC-8, a 16-bit
// instance for CRC-16 packet streams with backpressure and abort.
module tb_axis_lfsr_crc_engine;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance (a_*)
    logic       a_en, a_svalid, a_slast, a_sready, a_mvalid, a_mlast, a_mready;
    logic [1:0] a_mode;
    logic [7:0] a_poly, a_seed, a_init, a_sdata, a_mdata;
    logic [3:0] a_err;
    // 16-bit instance (b_*)
    logic        b_en, b_svalid, b_slast, b_sready, b_mvalid, b_mlast, b_mready;
    logic [1:0]  b_mode;
    logic [15:0] b_poly, b_seed, b_init, b_sdata, b_mdata;
    logic [31:0] b_err;

    logic [8:0]  a_q[$];
    logic [16:0] b_q[$];

    axis_lfsr_crc_engine #(
        .DATA_WIDTH   (8),
        .CRC_WIDTH    (8),
        .ERR_CNT_WIDTH(4)
    ) u_dut8 (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .en_i         (a_en),
        .mode_i       (a_mode),
        .poly_i       (a_poly),
        .seed_i       (a_seed),
        .crc_init_i   (a_init),
        .s_axis_tdata (a_sdata),
        .s_axis_tvalid(a_svalid),
        .s_axis_tlast (a_slast),
        .s_axis_tready(a_sready),
        .m_axis_tdata (a_mdata),
        .m_axis_tvalid(a_mvalid),
        .m_axis_tlast (a_mlast),
        .m_axis_tready(a_mready),
        .err_cnt_o    (a_err)
    );

    axis_lfsr_crc_engine #(
        .DATA_WIDTH   (16),
        .CRC_WIDTH    (16),
        .ERR_CNT_WIDTH(32)
    ) u_dut16 (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .en_i         (b_en),
        .mode_i       (b_mode),
        .poly_i       (b_poly),
        .seed_i       (b_seed),
        .crc_init_i   (b_init),
        .s_axis_tdata (b_sdata),
        .s_axis_tvalid(b_svalid),
        .s_axis_tlast (b_slast),
        .s_axis_tready(b_sready),
        .m_axis_tdata (b_mdata),
        .m_axis_tvalid(b_mvalid),
        .m_axis_tlast (b_mlast),
        .m_axis_tready(b_mready),
        .err_cnt_o    (b_err)
    );

    function automatic logic [7:0] lfsr8(input logic [7:0] v, input logic [7:0] p);
        return {v[6:0], 1'b0} ^ (v[7] ? p : 8'h00);
    endfunction

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d,
                                          input logic [15:0] p);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? p : 16'h0000);
        end
        return r;
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if ({a_mvalid, a_mdata, a_mlast, a_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a got v=%b d=%h l=%b e=%h want all 0", a_mvalid, a_mdata, a_mlast, a_err);
        end
        checks++;
        if ({b_mvalid, b_mdata, b_mlast, b_err, b_sready} !== 51'h0) begin
            errors++;
            $display("FAIL reset_b got v=%b d=%h l=%b e=%h r=%b want all 0",
                     b_mvalid, b_mdata, b_mlast, b_err, b_sready);
        end
        @(negedge clk);
        rstn = 1'b1;
        a_mode = 2'd0; a_poly = 8'h1D; a_seed = 8'h01; a_mready = 1'b1; a_en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_prestream got valid=%b want 1", a_mvalid);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({a_mvalid, a_mdata, a_mlast, a_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_midstream got v=%b d=%h l=%b e=%h want all 0",
                     a_mvalid, a_mdata, a_mlast, a_err);
        end
        @(negedge clk);
        a_en = 1'b0; rstn = 1'b1;
        b_mode = 2'd1; b_mready = 1'b1; b_en = 1'b0;
        #1;
        checks++;
        if (b_sready !== 1'b0) begin
            errors++;
            $display("FAIL reset_sready_disabled got %b want 0", b_sready);
        end
        @(negedge clk);
        b_en = 1'b1;
        #1;
        checks++;
        if (b_sready !== 1'b1) begin
            errors++;
            $display("FAIL reset_sready_enabled got %b want 1", b_sready);
        end
        @(negedge clk);
        b_en = 1'b0;
    endtask

    task automatic test_gen();
        int         cyc = 0;
        logic [8:0] e;
        logic [7:0] exp_d;
        logic       stall = 1'b0;
        logic [8:0] hold = '0;
        a_q.delete();
        foreach (a_q[i]) a_q.delete(i);
        a_q.push_back(9'h001); a_q.push_back(9'h002); a_q.push_back(9'h004);
        a_q.push_back(9'h008); a_q.push_back(9'h010); a_q.push_back(9'h020);
        a_q.push_back(9'h040); a_q.push_back(9'h080); a_q.push_back(9'h01D);
        a_mode = 2'd0; a_poly = 8'h1D; a_seed = 8'h01; a_mready = 1'b1;
        @(negedge clk);
        a_en = 1'b1;
        #1;
        checks++;
        if (a_sready !== 1'b0) begin
            errors++;
            $display("FAIL gen_sready got %b want 0", a_sready);
        end
        while (a_q.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            #1;
            if (a_mvalid && a_mready) begin
                e = a_q.pop_front();
                checks++;
                if ({a_mlast, a_mdata} !== e) begin
                    errors++;
                    $display("FAIL gen_seq got %h want %h", {a_mlast, a_mdata}, e);
                end
            end
        end
        checks++;
        if (a_q.size() != 0) begin
            errors++;
            $display("FAIL gen_timeout got %0d pending want 0", a_q.size());
        end
        exp_d = 8'h3A;
        repeat (40) begin
            @(negedge clk);
            a_mready = 1'($urandom_range(0, 1));
            #1;
            if (stall) begin
                checks++;
                if ({a_mvalid, a_mlast, a_mdata} !== {1'b1, hold}) begin
                    errors++;
                    $display("FAIL gen_hold got %h want %h", {a_mvalid, a_mlast, a_mdata}, {1'b1, hold});
                end
            end
            if (a_mvalid && a_mready) begin
                checks++;
                if ({a_mlast, a_mdata} !== {1'b0, exp_d}) begin
                    errors++;
                    $display("FAIL gen_bp_seq got %h want %h", {a_mlast, a_mdata}, {1'b0, exp_d});
                end
                exp_d = lfsr8(exp_d, 8'h1D);
            end
            stall = a_mvalid && !a_mready;
            hold  = {a_mlast, a_mdata};
        end
        @(negedge clk);
        a_en = 1'b0; a_mready = 1'b1;
    endtask

    task automatic test_crc_kat();
        logic [7:0] msg[9];
        logic [8:0] e;
        int         k = 0;
        int         cyc = 0;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        a_q.delete();
        for (int i = 0; i < 9; i++) a_q.push_back({1'b0, msg[i]});
        a_q.push_back({1'b1, 8'hF4});
        a_mode = 2'd1; a_poly = 8'h07; a_init = 8'h00; a_mready = 1'b1;
        @(negedge clk);
        a_en = 1'b1;
        while (a_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            a_svalid = (k < 9);
            a_sdata  = (k < 9) ? msg[k] : 8'h00;
            a_slast  = (k == 8);
            #1;
            if (a_mvalid && a_mready) begin
                e = a_q.pop_front();
                checks++;
                if ({a_mlast, a_mdata} !== e) begin
                    errors++;
                    $display("FAIL crc8_kat got %h want %h", {a_mlast, a_mdata}, e);
                end
            end
            if (a_svalid && a_sready) k++;
        end
        checks++;
        if (a_q.size() != 0) begin
            errors++;
            $display("FAIL crc8_timeout got %0d pending want 0", a_q.size());
        end
        @(negedge clk);
        a_svalid = 1'b0; a_slast = 1'b0; a_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] in_d[$];
        logic        in_l[$];
        logic [16:0] e;
        logic [16:0] hold = '0;
        logic        stall = 1'b0;
        logic [15:0] crc = 16'hFFFF;
        int          idx = 0;
        int          cyc = 0;
        int          outs = 0;
        int          n;
        logic        extra = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_d.push_back(16'h0031 + 16'(i));
            in_l.push_back(i == 8);
        end
        in_d.push_back(16'($urandom)); in_l.push_back(1'b1);
        for (int i = 0; i < 6; i++) begin
            in_d.push_back(16'($urandom));
            in_l.push_back(i == 5);
        end
        n = in_d.size();
        b_q.delete();
        b_mode = 2'd1; b_poly = 16'h1021; b_init = 16'hFFFF;
        @(negedge clk);
        b_en = 1'b1;
        while ((idx < n || b_q.size() > 0) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            b_svalid = (idx < n) && ($urandom_range(0, 3) != 0);
            b_sdata  = (idx < n) ? in_d[idx] : 16'h0000;
            b_slast  = (idx < n) ? in_l[idx] : 1'b0;
            b_mready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                checks++;
                if ({b_mvalid, b_mlast, b_mdata} !== {1'b1, hold}) begin
                    errors++;
                    $display("FAIL crc_hold got %h want %h", {b_mvalid, b_mlast, b_mdata}, {1'b1, hold});
                end
            end
            if (b_mvalid && b_mready) begin
                outs++;
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL crc_unexpected got %h want none", {b_mlast, b_mdata});
                end else begin
                    e = b_q.pop_front();
                    if ({b_mlast, b_mdata} !== e) begin
                        errors++;
                        $display("FAIL crc_beat got %h want %h", {b_mlast, b_mdata}, e);
                    end
                end
            end
            if (b_svalid && b_sready) begin
                b_q.push_back({1'b0, b_sdata});
                crc = crc16(crc, b_sdata, 16'h1021);
                if (b_slast) begin
                    b_q.push_back({1'b1, crc});
                    crc = 16'hFFFF;
                end
                idx++;
            end
            stall = b_mvalid && !b_mready;
            hold  = {b_mlast, b_mdata};
        end
        checks++;
        if (idx != n || b_q.size() != 0) begin
            errors++;
            $display("FAIL crc_timeout got idx=%0d pending=%0d want idx=%0d pending=0", idx, b_q.size(), n);
        end
        checks++;
        if (outs != n + 3) begin
            errors++;
            $display("FAIL crc_beat_count got %0d want %0d", outs, n + 3);
        end
        b_svalid = 1'b0; b_slast = 1'b0; b_mready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (b_mvalid) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL crc_extra_beat got 1 want 0");
        end
        b_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prbs_check();
        logic [7:0] exp_d = 8'h01;
        logic       rdy_ok = 1'b1;
        logic       mv_seen = 1'b0;
        a_mode = 2'd2; a_poly = 8'h1D; a_seed = 8'h01; a_mready = 1'b1;
        @(negedge clk);
        a_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_svalid = 1'b1;
            a_sdata  = (i == 3 || i == 7) ? (exp_d ^ 8'h5A) : exp_d;
            #1;
            if (a_sready !== 1'b1) rdy_ok = 1'b0;
            exp_d = lfsr8(exp_d, 8'h1D);
            @(negedge clk);
            if (a_mvalid !== 1'b0) mv_seen = 1'b1;
        end
        a_svalid = 1'b0;
        #1;
        checks++;
        if (a_err !== 4'd2) begin
            errors++;
            $display("FAIL chk_err_count got %0d want 2", a_err);
        end
        checks++;
        if (rdy_ok !== 1'b1) begin
            errors++;
            $display("FAIL chk_sready got 0 want 1");
        end
        checks++;
        if (mv_seen !== 1'b0) begin
            errors++;
            $display("FAIL chk_mvalid got 1 want 0");
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            a_svalid = 1'b1;
            a_sdata  = exp_d ^ 8'hFF;
            exp_d    = lfsr8(exp_d, 8'h1D);
            @(negedge clk);
        end
        a_svalid = 1'b0;
        #1;
        checks++;
        if (a_err !== 4'hF) begin
            errors++;
            $display("FAIL chk_saturate got %0d want 15", a_err);
        end
        @(negedge clk);
        a_en = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (a_err !== 4'd0) begin
            errors++;
            $display("FAIL chk_clear got %0d want 0", a_err);
        end
    endtask

    task automatic test_abort();
        logic        extra = 1'b0;
        logic [15:0] exp_crc;
        b_mode = 2'd1; b_poly = 16'h1021; b_init = 16'hFFFF; b_mready = 1'b1;
        @(negedge clk);
        b_en = 1'b1; b_svalid = 1'b1; b_sdata = 16'hAAAA; b_slast = 1'b0;
        @(negedge clk);
        b_sdata = 16'h5555; b_slast = 1'b1;
        @(negedge clk);
        b_svalid = 1'b0; b_slast = 1'b0;
        #1;
        checks++;
        if ({b_sready, b_mvalid, b_mlast, b_mdata} !== {3'b010, 16'h5555}) begin
            errors++;
            $display("FAIL abort_in_crc_state got r=%b v=%b l=%b d=%h want r=0 v=1 l=0 d=5555",
                     b_sready, b_mvalid, b_mlast, b_mdata);
        end
        b_mready = 1'b0;
        @(negedge clk);
        b_en = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({b_mvalid, b_mlast, b_mdata} !== 18'h0) begin
            errors++;
            $display("FAIL abort_clear got v=%b l=%b d=%h want 0", b_mvalid, b_mlast, b_mdata);
        end
        b_en = 1'b1; b_mready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (b_mvalid) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL abort_crc_emitted got 1 want 0");
        end
        exp_crc = crc16(crc16(16'hFFFF, 16'h1234, 16'h1021), 16'hBEEF, 16'h1021);
        @(negedge clk);
        b_svalid = 1'b1; b_sdata = 16'h1234; b_slast = 1'b0;
        @(negedge clk);
        b_sdata = 16'hBEEF; b_slast = 1'b1;
        #1;
        checks++;
        if ({b_mvalid, b_mlast, b_mdata} !== {2'b10, 16'h1234}) begin
            errors++;
            $display("FAIL abort_next_beat0 got %h want %h", {b_mvalid, b_mlast, b_mdata}, {2'b10, 16'h1234});
        end
        @(negedge clk);
        b_svalid = 1'b0; b_slast = 1'b0;
        #1;
        checks++;
        if ({b_mvalid, b_mlast, b_mdata} !== {2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL abort_next_beat1 got %h want %h", {b_mvalid, b_mlast, b_mdata}, {2'b10, 16'hBEEF});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({b_mvalid, b_mlast, b_mdata} !== {2'b11, exp_crc}) begin
            errors++;
            $display("FAIL abort_next_crc got %h want %h", {b_mvalid, b_mlast, b_mdata}, {2'b11, exp_crc});
        end
        @(negedge clk);
        b_en = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        a_en = 1'b0; a_mode = 2'd0; a_poly = 8'h00; a_seed = 8'h00; a_init = 8'h00;
        a_sdata = 8'h00; a_svalid = 1'b0; a_slast = 1'b0; a_mready = 1'b1;
        b_en = 1'b0; b_mode = 2'd0; b_poly = 16'h0000; b_seed = 16'h0001; b_init = 16'hFFFF;
        b_sdata = 16'h0000; b_svalid = 1'b0; b_slast = 1'b0; b_mready = 1'b1;
        test_reset();
        test_gen();
        test_crc_kat();
        test_back_to_back();
        test_prbs_check();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
